// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache tag controller:
// command encodings, controller FSM states and a constant log2 helper.
package cache_pkg;

  localparam logic [3:0] CMD_READ       = 4'd0;
  localparam logic [3:0] CMD_WRITE      = 4'd1;
  localparam logic [3:0] CMD_INVALIDATE = 4'd3;
  localparam logic [3:0] CMD_CLEAR      = 4'd8;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_WB     = 3'd3,
    ST_FILL   = 3'd4,
    ST_UPDATE = 3'd5,
    ST_RESP   = 3'd6
  } state_e;

  // Ceiling log2, used for elaboration-time widths.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res = res + 1;
    return res;
  endfunction

endpackage

// File: rtl/set_assoc_cache_ctrl_plru.sv
// Tree pseudo-LRU helper. Each node bit points toward the less recently used
// half; node n has children 2n+1 (bit 0) and 2n+2 (bit 1).
module plru_tree
  import cache_pkg::*;
#(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]          plru_bits,
  input  logic [clog2(WAYS)-1:0]   touch_way,
  output logic [clog2(WAYS)-1:0]   victim_way,
  output logic [WAYS-2:0]          next_bits
);
  localparam int WAY_W = clog2(WAYS);

  logic [WAY_W-1:0] vnode_s;
  logic [WAY_W-1:0] tnode_s;

  // Follow the node bits from the root down to the least recently used leaf.
  always_comb begin
    vnode_s    = '0;
    victim_way = '0;
    for (int l = 0; l < WAY_W; l++) begin
      victim_way[WAY_W-1-l] = plru_bits[vnode_s];
      vnode_s = (vnode_s << 1) + WAY_W'(1'b1) + WAY_W'(plru_bits[vnode_s]);
    end
  end

  // Walk the touched way's path, pointing every node on it away from that way.
  always_comb begin
    next_bits = plru_bits;
    tnode_s   = '0;
    for (int l = 0; l < WAY_W; l++) begin
      next_bits[tnode_s] = ~touch_way[WAY_W-1-l];
      tnode_s = (tnode_s << 1) + WAY_W'(1'b1) + WAY_W'(touch_way[WAY_W-1-l]);
    end
  end

endmodule

// File: rtl/set_assoc_cache_ctrl.sv
// N-way set-associative write-back/write-allocate tag controller with
// tree-PLRU replacement and a single-outstanding valid/ready memory port.
// Optional statistics counters are built when CACHE_STATS_EN is defined.
module set_assoc_cache_ctrl
  import cache_pkg::*;
#(
  parameter int SETS     = 16384,
  parameter int WAYS     = 4,
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [3:0]                 req_cmd,
  input  logic [ADDR_W-1:0]          req_addr,
  output logic                       resp_valid,
  output logic                       resp_hit,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic                       mem_we,
  output logic [ADDR_W-OFFSET_W-1:0] mem_addr
`ifdef CACHE_STATS_EN
  , output logic [31:0]              hit_cnt
  , output logic [31:0]              miss_cnt
  , output logic [31:0]              read_cnt
  , output logic [31:0]              write_cnt
  , output logic [31:0]              wb_cnt
`endif
);
  localparam int IDX_W  = clog2(SETS);
  localparam int WAY_W  = clog2(WAYS);
  localparam int LINE_W = ADDR_W - OFFSET_W;
  localparam int TAG_W  = LINE_W - IDX_W;

  // Tag/state arrays, indexed [set][way]; no reset, the INIT sweep clears V/D/PLRU.
  logic [TAG_W-1:0] tag_mem   [SETS][WAYS];
  logic [WAYS-1:0]  valid_mem [SETS];
  logic [WAYS-1:0]  dirty_mem [SETS];
  logic [WAYS-2:0]  plru_mem  [SETS];

  state_e            state_r, next_s;
  logic [LINE_W-1:0] line_r;
  logic [3:0]        cmd_r;
  logic [IDX_W-1:0]  init_idx_r, idx_s;
  logic [TAG_W-1:0]  tag_s;
  logic [WAY_W-1:0]  victim_r, hit_way_s, inv_way_s, plru_way_s, sel_way_s, touch_way_s;
  logic [WAYS-2:0]   plru_next_s;
  logic              hit_s, any_inv_s, sel_dirty_s, is_rw_s, accept_s;
  logic              clear_pend_r, hit_flag_r;
  logic [LINE_W-1:0] wb_addr_s, mem_addr_next_s;
  logic              req_ready_next_s, resp_valid_next_s, resp_hit_next_s;
  logic              mem_valid_next_s, mem_we_next_s;

  assign accept_s    = req_valid && req_ready;
  assign idx_s       = line_r[IDX_W-1:0];
  assign tag_s       = line_r[LINE_W-1:IDX_W];
  assign is_rw_s     = (cmd_r == CMD_READ) || (cmd_r == CMD_WRITE);
  assign touch_way_s = (state_r == ST_UPDATE) ? victim_r : hit_way_s;

  plru_tree #(.WAYS(WAYS)) u_plru (
    .plru_bits  (plru_mem[idx_s]),
    .touch_way  (touch_way_s),
    .victim_way (plru_way_s),
    .next_bits  (plru_next_s)
  );

  // Tag compare and invalid-way search; descending scan leaves the lowest index.
  always_comb begin
    hit_s     = 1'b0;
    hit_way_s = '0;
    any_inv_s = 1'b0;
    inv_way_s = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_mem[idx_s][w] && (tag_mem[idx_s][w] == tag_s)) begin
        hit_s     = 1'b1;
        hit_way_s = WAY_W'(w);
      end else begin
        hit_s     = hit_s;
      end
      if (!valid_mem[idx_s][w]) begin
        any_inv_s = 1'b1;
        inv_way_s = WAY_W'(w);
      end else begin
        any_inv_s = any_inv_s;
      end
    end
    if (cmd_r == CMD_INVALIDATE) begin
      sel_way_s = hit_way_s;
    end else begin
      sel_way_s = any_inv_s ? inv_way_s : plru_way_s;
    end
    sel_dirty_s = valid_mem[idx_s][sel_way_s] && dirty_mem[idx_s][sel_way_s];
    wb_addr_s   = {tag_mem[idx_s][sel_way_s], idx_s};
  end

  // FSM state register plus the request/victim context it carries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_INIT;
      init_idx_r   <= '0;
      clear_pend_r <= 1'b0;
      hit_flag_r   <= 1'b0;
      cmd_r        <= 4'd0;
      line_r       <= '0;
      victim_r     <= '0;
    end else begin
      state_r    <= next_s;
      init_idx_r <= (state_r == ST_INIT) ? init_idx_r + IDX_W'(1'b1) : '0;
      if (accept_s) begin
        cmd_r        <= req_cmd;
        line_r       <= req_addr[ADDR_W-1:OFFSET_W];
        clear_pend_r <= (req_cmd == CMD_CLEAR);
        hit_flag_r   <= 1'b0;
      end else if (state_r == ST_LOOKUP) begin
        victim_r   <= sel_way_s;
        hit_flag_r <= hit_s && is_rw_s;
      end else if ((state_r == ST_INIT) && (next_s != ST_INIT)) begin
        clear_pend_r <= 1'b0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (init_idx_r == IDX_W'(SETS - 1)) next_s = clear_pend_r ? ST_RESP : ST_IDLE;
        else                                next_s = ST_INIT;
      end
      ST_IDLE: begin
        if (accept_s) next_s = (req_cmd == CMD_CLEAR) ? ST_INIT : ST_LOOKUP;
        else          next_s = ST_IDLE;
      end
      ST_LOOKUP: begin
        if (is_rw_s) begin
          if (hit_s)            next_s = ST_RESP;
          else if (sel_dirty_s) next_s = ST_WB;
          else                  next_s = ST_FILL;
        end else if ((cmd_r == CMD_INVALIDATE) && hit_s && sel_dirty_s) begin
          next_s = ST_WB;
        end else begin
          next_s = ST_RESP;
        end
      end
      ST_WB: begin
        if (mem_ready) next_s = (cmd_r == CMD_INVALIDATE) ? ST_UPDATE : ST_FILL;
        else           next_s = ST_WB;
      end
      ST_FILL: begin
        if (mem_ready) next_s = ST_UPDATE;
        else           next_s = ST_FILL;
      end
      ST_UPDATE: next_s = ST_RESP;
      ST_RESP:   next_s = ST_IDLE;
      default:   next_s = ST_INIT;
    endcase
  end

  // Output decode; resp trails the RESP state by one register stage.
  always_comb begin
    req_ready_next_s  = (next_s == ST_IDLE);
    resp_valid_next_s = (state_r == ST_RESP);
    resp_hit_next_s   = (state_r == ST_RESP) && hit_flag_r;
    mem_valid_next_s  = (next_s == ST_WB) || (next_s == ST_FILL);
    mem_we_next_s     = (next_s == ST_WB);
    if ((next_s == ST_WB) && (state_r == ST_LOOKUP)) begin
      mem_addr_next_s = wb_addr_s;
    end else if (next_s == ST_FILL) begin
      mem_addr_next_s = line_r;
    end else begin
      mem_addr_next_s = mem_addr;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
    end else begin
      req_ready  <= req_ready_next_s;
      resp_valid <= resp_valid_next_s;
      resp_hit   <= resp_hit_next_s;
      mem_valid  <= mem_valid_next_s;
      mem_we     <= mem_we_next_s;
      mem_addr   <= mem_addr_next_s;
    end
  end

  // Array updates: INIT sweep, hit touch/dirty, invalidation and line install.
  always_ff @(posedge clk) begin
    case (state_r)
      ST_INIT: begin
        valid_mem[init_idx_r] <= '0;
        dirty_mem[init_idx_r] <= '0;
        plru_mem[init_idx_r]  <= '0;
      end
      ST_LOOKUP: begin
        if (is_rw_s && hit_s) begin
          plru_mem[idx_s] <= plru_next_s;
          if (cmd_r == CMD_WRITE) dirty_mem[idx_s][hit_way_s] <= 1'b1;
        end
        if ((cmd_r == CMD_INVALIDATE) && hit_s && !sel_dirty_s) begin
          valid_mem[idx_s][hit_way_s] <= 1'b0;
        end
      end
      ST_UPDATE: begin
        if (cmd_r == CMD_INVALIDATE) begin
          valid_mem[idx_s][victim_r] <= 1'b0;
          dirty_mem[idx_s][victim_r] <= 1'b0;
        end else begin
          tag_mem[idx_s][victim_r]   <= tag_s;
          valid_mem[idx_s][victim_r] <= 1'b1;
          dirty_mem[idx_s][victim_r] <= (cmd_r == CMD_WRITE);
          plru_mem[idx_s]            <= plru_next_s;
        end
      end
      default: ;
    endcase
  end

`ifdef CACHE_STATS_EN
  // Statistics: accesses on accept, hit/miss in LOOKUP, write-backs on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt   <= 32'd0;
      miss_cnt  <= 32'd0;
      read_cnt  <= 32'd0;
      write_cnt <= 32'd0;
      wb_cnt    <= 32'd0;
    end else if (accept_s && (req_cmd == CMD_CLEAR)) begin
      hit_cnt   <= 32'd0;
      miss_cnt  <= 32'd0;
      read_cnt  <= 32'd0;
      write_cnt <= 32'd0;
      wb_cnt    <= 32'd0;
    end else begin
      if (accept_s && (req_cmd == CMD_READ))  read_cnt  <= read_cnt + 32'd1;
      if (accept_s && (req_cmd == CMD_WRITE)) write_cnt <= write_cnt + 32'd1;
      if ((state_r == ST_LOOKUP) && is_rw_s && hit_s)  hit_cnt  <= hit_cnt + 32'd1;
      if ((state_r == ST_LOOKUP) && is_rw_s && !hit_s) miss_cnt <= miss_cnt + 32'd1;
      if ((state_r == ST_WB) && mem_ready)             wb_cnt   <= wb_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Scoreboard bench for set_assoc_cache_ctrl (small SETS for short INIT sweeps).
module tb_set_assoc_cache_ctrl;
  localparam int SETS     = 64;
  localparam int WAYS     = 4;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 6;
  localparam int LINE_W   = ADDR_W - OFFSET_W;

  localparam logic [3:0] C_READ  = 4'd0;
  localparam logic [3:0] C_WRITE = 4'd1;
  localparam logic [3:0] C_INV   = 4'd3;
  localparam logic [3:0] C_CLEAR = 4'd8;
  localparam logic [3:0] C_NOP   = 4'd2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready;
  logic [3:0]        req_cmd;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid, resp_hit;
  logic              mem_valid, mem_ready, mem_we;
  logic [LINE_W-1:0] mem_addr;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt, read_cnt, write_cnt, wb_cnt;
`endif

  set_assoc_cache_ctrl #(.SETS(SETS), .WAYS(WAYS), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_hit(resp_hit),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .read_cnt(read_cnt)
    , .write_cnt(write_cnt), .wb_cnt(wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic hit; logic chk_lat; int acc; } resp_exp_t;
  typedef struct { logic we; logic [LINE_W-1:0] addr; } mem_exp_t;

  resp_exp_t resp_q[$];
  mem_exp_t  mem_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_delay = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_mem(input logic we, input logic [LINE_W-1:0] addr);
    mem_exp_t e;
    e.we = we;
    e.addr = addr;
    mem_q.push_back(e);
  endtask

  // Issue one request, wait for acceptance, then queue the expected response.
  task automatic send(input logic [3:0] cmd, input logic [ADDR_W-1:0] addr,
                      input logic hit, input logic chk_lat);
    resp_exp_t e;
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_addr  = addr;
    n = 0;
    while (!req_ready && n < 4 * SETS) begin
      @(negedge clk);
      n = n + 1;
    end
    if (!req_ready) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL accept_timeout: cmd %0d addr 0x%0h not accepted", cmd, addr);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_cmd   = 4'd0;
      req_addr  = 32'hDEAD_BEEF;
      e.hit     = hit;
      e.chk_lat = chk_lat;
      e.acc     = cyc;
      resp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while ((resp_q.size() != 0 || mem_q.size() != 0) && n < bound) begin
      @(negedge clk);
      n = n + 1;
    end
    if (resp_q.size() != 0 || mem_q.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL done_timeout: %0d resp and %0d mem expectations left", resp_q.size(), mem_q.size());
      resp_q.delete();
      mem_q.delete();
    end
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (!req_ready && n < 4 * SETS) begin
      @(negedge clk);
      n = n + 1;
    end
    check(name, n, SETS);
  endtask

  // Next-level memory model: accepts after mem_delay cycles of mem_valid.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ready) begin
        mem_ready = 1'b0;
        wcnt = 0;
      end else if (mem_valid) begin
        if (wcnt >= mem_delay) mem_ready = 1'b1;
        else wcnt = wcnt + 1;
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a response or memory transfer.
  initial begin
    resp_exp_t re;
    mem_exp_t  me;
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid) begin
        if (resp_q.size() == 0) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL unexpected_resp: resp_hit %0b with nothing expected", resp_hit);
        end else begin
          re = resp_q.pop_front();
          check("resp_hit", resp_hit, re.hit);
          if (re.chk_lat) check("hit_latency", cyc - re.acc, 2);
        end
      end
      if (rst_n && mem_valid && mem_ready) begin
        if (mem_q.size() == 0) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL unexpected_mem: we %0b addr 0x%0h", mem_we, mem_addr);
        end else begin
          me = mem_q.pop_front();
          check("mem_we", mem_we, me.we);
          check("mem_addr", mem_addr, me.addr);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_cmd = 4'd0; req_addr = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_hit", resp_hit, 0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst_n = 1'b1;
    wait_init("init_cycles");

    // Cold miss then hit on the same line.
    exp_mem(1'b0, 26'h1);
    send(C_READ, 32'h0000_0040, 1'b0, 1'b0);
    wait_done(200);
    send(C_READ, 32'h0000_0040, 1'b1, 1'b1);
    wait_done(200);
`ifdef CACHE_STATS_EN
    check("read_cnt_a", read_cnt, 2);
    check("hit_cnt_a", hit_cnt, 1);
    check("miss_cnt_a", miss_cnt, 1);
`endif

    // Five dirty tags in set 0: the fifth evicts way 0 (tag 1) via write-back.
    for (int k = 1; k <= 4; k++) begin
      exp_mem(1'b0, LINE_W'(k << 6));
      send(C_WRITE, 32'(k << 12), 1'b0, 1'b0);
      wait_done(200);
    end
    exp_mem(1'b1, 26'h40);
    exp_mem(1'b0, 26'h140);
    send(C_WRITE, 32'h0000_5000, 1'b0, 1'b0);
    wait_done(200);
    send(C_WRITE, 32'h0000_2000, 1'b1, 1'b1);
    wait_done(200);
`ifdef CACHE_STATS_EN
    check("wb_cnt_a", wb_cnt, 1);
    check("write_cnt_a", write_cnt, 6);
    check("miss_cnt_b", miss_cnt, 6);
`endif

    // Stalled fill: request held stable while mem_ready stays low.
    mem_delay = 10;
    exp_mem(1'b0, 26'h81);
    send(C_READ, 32'h0000_2040, 1'b0, 1'b0);
    n = 0;
    while (!mem_valid && n < 20) begin
      @(negedge clk);
      n = n + 1;
    end
    for (int i = 0; i < 10; i++) begin
      check("fill_hold", {mem_valid, mem_we, req_ready, resp_valid, mem_addr},
            {1'b1, 1'b0, 1'b0, 1'b0, 26'h81});
      @(negedge clk);
    end
    wait_done(200);
    mem_delay = 0;

    // Invalidate dirty, re-read, invalidate absent and clean lines, NOP.
    exp_mem(1'b1, 26'h80);
    send(C_INV, 32'h0000_2000, 1'b0, 1'b0);
    wait_done(200);
    exp_mem(1'b0, 26'h80);
    send(C_READ, 32'h0000_2000, 1'b0, 1'b0);
    wait_done(200);
    send(C_INV, 32'h0000_7000, 1'b0, 1'b0);
    wait_done(200);
    send(C_INV, 32'h0000_2000, 1'b0, 1'b0);
    wait_done(200);
    exp_mem(1'b0, 26'h80);
    send(C_READ, 32'h0000_2000, 1'b0, 1'b0);
    wait_done(200);
    send(C_NOP, 32'h0000_0040, 1'b0, 1'b0);
    wait_done(200);
    send(C_READ, 32'h0000_0040, 1'b1, 1'b1);
    wait_done(200);

    // CLEAR: full sweep, then everything misses.
    send(C_CLEAR, 32'h0, 1'b0, 1'b0);
    wait_done(4 * SETS);
`ifdef CACHE_STATS_EN
    check("clear_counters", {hit_cnt, miss_cnt, read_cnt, write_cnt, wb_cnt}, 160'd0);
`endif
    exp_mem(1'b0, 26'h1);
    send(C_READ, 32'h0000_0040, 1'b0, 1'b0);
    wait_done(200);

    // Reset in the middle of a write-back.
    send(C_WRITE, 32'h0000_0040, 1'b1, 1'b0);
    wait_done(200);
    mem_delay = 50;
    send(C_INV, 32'h0000_0040, 1'b0, 1'b0);
    n = 0;
    while (!(mem_valid && mem_we) && n < 20) begin
      @(negedge clk);
      n = n + 1;
    end
    check("wb_started", {mem_valid, mem_we, mem_addr}, {1'b1, 1'b1, 26'h1});
    #2;
    rst_n = 1'b0;
    resp_q.delete();
    mem_q.delete();
    #1;
    check("rst_mid_wb", {mem_valid, mem_we, mem_addr, req_ready, resp_valid, resp_hit}, 31'd0);
    mem_delay = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_init("init_after_rst");
`ifdef CACHE_STATS_EN
    check("rst_counters", {hit_cnt, miss_cnt, read_cnt, write_cnt, wb_cnt}, 160'd0);
`endif
    exp_mem(1'b0, 26'h1);
    send(C_READ, 32'h0000_0040, 1'b0, 1'b0);
    wait_done(200);
    exp_mem(1'b0, 26'h81);
    send(C_READ, 32'h0000_2040, 1'b0, 1'b0);
    wait_done(200);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
